mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbiter and sequencer that shares the single-port 1024x16 unified RAM between instruction fetch (IF) and the memory stage (MEM) of the pipelined processor.
- Grants at most one RAM access per cycle and gives MEM priority, with a starvation guard for IF.
- Sequences two-word instruction fetches as a locked burst.
- Returns read data one cycle after each access, steered to its owner.

Parameters:
ADDR_W, 10, RAM address width (word addressed)
DATA_W, 16, RAM word width
MAX_STARVE, 3, consecutive denied IF cycles after which IF wins over MEM (1..7)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
IF_REQ  in  1  fetch request; held with IF_ADDR/IF_TWO stable until IF_ACK, may drop anytime (flush)
IF_ADDR  in  ADDR_W  fetch address (first word)
IF_TWO  in  1  1 = two-word fetch (IF_ADDR, IF_ADDR+1)
IF_ACK  out  1  RAM access for IF issued this cycle
IF_VALID  out  1  IF_DATA valid this cycle
IF_WORD  out  1  0 = first word, 1 = second word of burst
IF_DATA  out  DATA_W  fetched word
MEM_REQ  in  1  memory-stage request; held stable until MEM_ACK
MEM_WE  in  1  1 = write, 0 = read
MEM_ADDR  in  ADDR_W  data address
MEM_WDATA  in  DATA_W  write data
MEM_ACK  out  1  RAM access for MEM issued this cycle
MEM_VALID  out  1  MEM_RDATA valid (reads only)
MEM_RDATA  out  DATA_W  read word
RAM_WR  out  1  RAM write enable
RAM_ADDR  out  ADDR_W  RAM address
RAM_DIN  out  DATA_W  RAM write data
RAM_DOUT  in  DATA_W  RAM read data, valid the cycle after the address is sampled

Behaviour:
- Reset (async, RST_N=0): state ST_IDLE, starve counter 0, owner tag OWN_NONE, burst base 0. IF_VALID, MEM_VALID, IF_WORD, IF_ACK, MEM_ACK and RAM_WR are 0. RAM_ADDR and RAM_DIN are 0.
- Grant is combinational from the current state and requests. RAM_WR, RAM_ADDR and RAM_DIN are muxed from the granted requester and sampled by the RAM at the next CLK edge.
- When no grant: RAM_WR=0, RAM_ADDR=0, RAM_DIN=0.
- ST_IDLE arbitration:
  - MEM_REQ and IF_REQ both high, starve count < MAX_STARVE: grant MEM.
  - Starve count == MAX_STARVE: grant IF.
  - Only one requester high: grant it.
- Starve counter:
  - Increments (saturating at MAX_STARVE) each cycle IF_REQ=1 and IF is not granted.
  - Clears on any IF grant or when IF_REQ=0.
- IF grant with IF_TWO=1:
  - Register base = IF_ADDR and go to ST_IF_SECOND.
  - In ST_IF_SECOND, if IF_REQ=1: grant IF unconditionally at address base+1, with wrap-around 1023 -> 0. MEM is held off and its starve is not tracked. IF_ACK=1, then return to ST_IDLE.
  - In ST_IF_SECOND, if IF_REQ=0 (flush): no access, return to ST_IDLE, and MEM may be granted in that same cycle.
- MEM write grant: RAM_WR=1, RAM_DIN=MEM_WDATA, MEM_ACK=1. No MEM_VALID follows.
- Response path:
  - Owner tag and word index are registered on each read grant.
  - In the next cycle the owner's VALID=1 and its DATA = RAM_DOUT (combinational pass-through). The other DATA output is 0.
  - VALID is high for exactly 1 cycle per read access.
  - Back-to-back reads give back-to-back VALIDs, latency 1.
- Read issued in the cycle after a write to the same address returns the new data; the RAM provides this ordering.
- An IF flush does not suppress a response already in flight: VALID still pulses, and IF discards it.
- Reset mid-burst: the second word is never issued and any pending VALID is dropped.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding ST_IDLE and ST_IF_SECOND.
  - Owner tags OWN_NONE, OWN_IF and OWN_MEM.
  - Default ADDR_W/DATA_W constants.
  - Starve counter width (3 bits).
- Optional sub-module mem_arb_starve_ctr: saturating counter with clear, inputs IF_REQ and if_grant, output at_max.
- Everything else stays flat.

Test Plan:
- Reset: RST_N low mid-cycle -> all outputs 0 immediately. After release, MEM read of 0x005 (RAM holds 0x1234) -> MEM_ACK at cycle t, MEM_VALID=1 and MEM_RDATA=0x1234 at t+1.
- Contention: IF_REQ and MEM_REQ both held high with MEM re-requesting every cycle, MAX_STARVE=3 -> grants MEM,MEM,MEM,IF,MEM..., and the starve counter clears after the IF grant.
- Two-word fetch at 0x3FF, RAM[0x3FF]=0xAAAA, RAM[0x000]=0x5555, MEM_REQ high throughout:
  - RAM_ADDR 0x3FF then 0x000 on consecutive cycles, MEM blocked during the burst.
  - IF_VALID with IF_DATA=0xAAAA (IF_WORD=0) then 0x5555 (IF_WORD=1).
- Flush: two-word fetch at 0x010, IF_REQ dropped in the ST_IF_SECOND cycle with MEM_REQ pending -> no access to 0x011, MEM_ACK that same cycle, and one IF_VALID for the word at 0x010.
- Write then read: MEM write 0xBEEF to 0x020 (RAM_WR=1 for one cycle, no MEM_VALID), then MEM read of 0x020 -> MEM_RDATA=0xBEEF one cycle after that read's MEM_ACK.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-RAM port arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int STARVE_W = 3;
  typedef enum logic {ST_IDLE, ST_IF_SECOND} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} own_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, memory-stage and RAM signals shared by the arbiter and its clients
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_two;
  logic              if_ack;
  logic              if_valid;
  logic              if_word;
  logic [DATA_W-1:0] if_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  modport master (
    output if_req, if_addr, if_two, mem_req, mem_we, mem_addr, mem_wdata, ram_dout,
    input  if_ack, if_valid, if_word, if_data, mem_ack, mem_valid, mem_rdata,
           ram_wr, ram_addr, ram_din
  );
  modport slave (
    input  if_req, if_addr, if_two, mem_req, mem_we, mem_addr, mem_wdata, ram_dout,
    output if_ack, if_valid, if_word, if_data, mem_ack, mem_valid, mem_rdata,
           ram_wr, ram_addr, ram_din
  );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// mem_arb_starve_ctr: counts consecutive denied fetch cycles, saturating at MAX_STARVE
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req_i,
  input  logic if_grant_i,
  output logic at_max_o
);
  localparam logic [STARVE_W-1:0] MAX = STARVE_W'(MAX_STARVE);
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (!if_req_i || if_grant_i) ? '0 : (cnt_q == MAX) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign at_max_o = cnt_q == MAX;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch and memory stage, MEM-first with IF starvation guard
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_STARVE = 3
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  state_e state_q, state_d;
  own_e own_q, own_d;
  logic word_q, word_d;
  logic [ADDR_W-1:0] base_q, base_d, second_addr;
  logic [DATA_W-1:0] rdata;
  logic second, if_grant, mem_grant, at_max;
  mem_arb_starve_ctr #(.MAX_STARVE(MAX_STARVE)) u_starve (
    .clk(clk), .rst_n(rst_n), .if_req_i(bus.if_req), .if_grant_i(if_grant), .at_max_o(at_max)
  );
  // grants are gated by rst_n so every RAM-side output is quiet while reset is held
  always_comb begin
    second = state_q == ST_IF_SECOND;
    second_addr = base_q + 1'b1;
    if_grant = rst_n && (second ? bus.if_req : bus.if_req && (!bus.mem_req || at_max));
    mem_grant = rst_n && bus.mem_req && !if_grant;
    state_d = (!second && if_grant && bus.if_two) ? ST_IF_SECOND : ST_IDLE;
    base_d = (!second && if_grant) ? bus.if_addr : base_q;
    own_d = if_grant ? OWN_IF : (mem_grant && !bus.mem_we) ? OWN_MEM : OWN_NONE;
    word_d = if_grant && second;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q <= OWN_NONE;
      word_q <= 1'b0;
      base_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      word_q <= word_d;
      base_q <= base_d;
    end
  assign rdata = bus.ram_dout;
  assign bus.if_ack = if_grant;
  assign bus.mem_ack = mem_grant;
  assign bus.ram_wr = mem_grant && bus.mem_we;
  assign bus.ram_addr = if_grant ? (second ? second_addr : bus.if_addr) : mem_grant ? bus.mem_addr : '0;
  assign bus.ram_din = (mem_grant && bus.mem_we) ? bus.mem_wdata : '0;
  assign bus.if_valid = own_q == OWN_IF;
  assign bus.mem_valid = own_q == OWN_MEM;
  assign bus.if_word = word_q;
  assign bus.if_data = (own_q == OWN_IF) ? rdata : '0;
  assign bus.mem_rdata = (own_q == OWN_MEM) ? rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a rule-level arbitration model
module tb_mem_port_arbiter;
  localparam int MAXS = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [15:0] ram [1024];
  logic [15:0] shadow [1024];
  logic pk = 1'b0;
  logic [9:0] pk_a = '0;
  logic [15:0] pk_d = '0;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.MAX_STARVE(MAXS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_din;
    else if (pk) ram[pk_a] <= pk_d;
    bus.ram_dout <= ram[bus.ram_addr];
  end
  function automatic logic [9:0] raddr();
    return {($urandom_range(0, 1) != 0) ? 6'h3f : 6'h00, 4'($urandom_range(0, 15))};
  endfunction
  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = '0; bus.if_two = 0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
  endtask
  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      pk = 1; pk_a = 10'(i);
      case (i)
        'h005: pk_d = 16'h1234;
        'h3ff: pk_d = 16'hAAAA;
        'h000: pk_d = 16'h5555;
        'h010: pk_d = 16'h1010;
        'h011: pk_d = 16'hDEAD;
        'h030: pk_d = 16'h7777;
        default: pk_d = 16'($urandom);
      endcase
      @(posedge clk); #1;
    end
    pk = 0;
  endtask
  task automatic test_reset();
    @(negedge clk); rst_n = 1;
    bus.if_req = 1; bus.if_addr = 10'h040; bus.if_two = 1;
    #1; checks++; if (bus.if_ack !== 1'b1) begin errors++; $display("FAIL rst_pre_ack got=%b want=1", bus.if_ack); end
    @(posedge clk); #2; rst_n = 0; #1;
    checks++; if ({bus.if_ack, bus.mem_ack, bus.ram_wr, bus.if_valid, bus.mem_valid, bus.if_word} !== 6'b0)
      begin errors++; $display("FAIL rst_flags got=%b want=000000", {bus.if_ack, bus.mem_ack, bus.ram_wr, bus.if_valid, bus.mem_valid, bus.if_word}); end
    checks++; if ({bus.ram_addr, bus.ram_din} !== 26'h0) begin errors++; $display("FAIL rst_ram got=%h/%h want=0/0", bus.ram_addr, bus.ram_din); end
    @(negedge clk); idle_inputs(); rst_n = 1;
    @(negedge clk); bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 10'h005; #1;
    checks++; if ({bus.mem_ack, bus.if_ack, bus.ram_addr} !== {2'b10, 10'h005}) begin errors++; $display("FAIL rd5_issue got=%b%b/%h want=10/005", bus.mem_ack, bus.if_ack, bus.ram_addr); end
    @(negedge clk); bus.mem_req = 0; #1;
    checks++; if ({bus.mem_valid, bus.mem_rdata} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL rd5_data got=%b/%h want=1/1234", bus.mem_valid, bus.mem_rdata); end
    checks++; if ({bus.if_valid, bus.if_data} !== 17'h0) begin errors++; $display("FAIL rd5_ifside got=%b/%h want=0/0000", bus.if_valid, bus.if_data); end
  endtask
  task automatic test_contention();
    @(negedge clk);
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 10'h040;
    bus.if_req = 1; bus.if_addr = 10'h050; bus.if_two = 0;
    for (int i = 0; i < 9; i++) begin
      #1; checks++;
      if ({bus.if_ack, bus.mem_ack} !== ((i % 4 == 3) ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL contend_%0d got if/mem=%b%b want=%b", i, bus.if_ack, bus.mem_ack, (i % 4 == 3) ? 2'b10 : 2'b01); end
      @(negedge clk);
    end
    idle_inputs();
  endtask
  task automatic test_burst_wrap();
    int n;
    @(negedge clk);
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 10'h200;
    bus.if_req = 1; bus.if_addr = 10'h3ff; bus.if_two = 1;
    n = 0;
    #1;
    while (!bus.if_ack && n < 8) begin @(negedge clk); #1; n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL burst_wait got=%0d want=3 cycles", n); end
    checks++; if ({bus.mem_ack, bus.ram_addr} !== {1'b0, 10'h3ff}) begin errors++; $display("FAIL burst_w0 got=%b/%h want=0/3ff", bus.mem_ack, bus.ram_addr); end
    @(negedge clk); #1;
    checks++; if ({bus.if_ack, bus.mem_ack, bus.ram_addr} !== {2'b10, 10'h000}) begin errors++; $display("FAIL burst_w1 got=%b%b/%h want=10/000", bus.if_ack, bus.mem_ack, bus.ram_addr); end
    checks++; if ({bus.if_valid, bus.if_word, bus.if_data} !== {2'b10, 16'hAAAA}) begin errors++; $display("FAIL burst_d0 got=%b%b/%h want=10/aaaa", bus.if_valid, bus.if_word, bus.if_data); end
    @(negedge clk); bus.if_req = 0; #1;
    checks++; if (bus.mem_ack !== 1'b1) begin errors++; $display("FAIL burst_memresume got=%b want=1", bus.mem_ack); end
    checks++; if ({bus.if_valid, bus.if_word, bus.if_data} !== {2'b11, 16'h5555}) begin errors++; $display("FAIL burst_d1 got=%b%b/%h want=11/5555", bus.if_valid, bus.if_word, bus.if_data); end
    @(negedge clk); idle_inputs();
  endtask
  task automatic test_flush();
    @(negedge clk); bus.if_req = 1; bus.if_addr = 10'h010; bus.if_two = 1; #1;
    checks++; if ({bus.if_ack, bus.ram_addr} !== {1'b1, 10'h010}) begin errors++; $display("FAIL flush_w0 got=%b/%h want=1/010", bus.if_ack, bus.ram_addr); end
    @(negedge clk); bus.if_req = 0; bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 10'h030; #1;
    checks++; if ({bus.if_ack, bus.mem_ack, bus.ram_addr} !== {2'b01, 10'h030}) begin errors++; $display("FAIL flush_mem got=%b%b/%h want=01/030", bus.if_ack, bus.mem_ack, bus.ram_addr); end
    checks++; if ({bus.if_valid, bus.if_word, bus.if_data} !== {2'b10, 16'h1010}) begin errors++; $display("FAIL flush_ifd got=%b%b/%h want=10/1010", bus.if_valid, bus.if_word, bus.if_data); end
    @(negedge clk); bus.mem_req = 0; #1;
    checks++; if ({bus.if_valid, bus.mem_valid, bus.mem_rdata} !== {2'b01, 16'h7777}) begin errors++; $display("FAIL flush_memd got=%b%b/%h want=01/7777", bus.if_valid, bus.mem_valid, bus.mem_rdata); end
  endtask
  task automatic test_write_read();
    @(negedge clk); bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 10'h020; bus.mem_wdata = 16'hBEEF; #1;
    checks++; if ({bus.mem_ack, bus.ram_wr, bus.ram_addr, bus.ram_din} !== {2'b11, 10'h020, 16'hBEEF})
      begin errors++; $display("FAIL wr_issue got=%b%b/%h/%h want=11/020/beef", bus.mem_ack, bus.ram_wr, bus.ram_addr, bus.ram_din); end
    @(negedge clk); bus.mem_we = 0; #1;
    checks++; if ({bus.mem_ack, bus.ram_wr, bus.mem_valid} !== 3'b100) begin errors++; $display("FAIL rd_issue got=%b%b%b want=100", bus.mem_ack, bus.ram_wr, bus.mem_valid); end
    @(negedge clk); bus.mem_req = 0; #1;
    checks++; if ({bus.mem_valid, bus.mem_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL raw_data got=%b/%h want=1/beef", bus.mem_valid, bus.mem_rdata); end
    @(negedge clk); @(negedge clk);
  endtask
  task automatic test_random();
    logic sp = 0, drop_if = 0, drop_mem = 0, eif, emem, ewr, rword = 0;
    int base = 0, denied = 0, rown = 0, eaddr;
    logic [15:0] rdat = '0, edin;
    for (int i = 0; i < 1024; i++) shadow[i] = ram[i];
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (drop_if) bus.if_req = 0;
      if (drop_mem) bus.mem_req = 0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin bus.if_req = 1; bus.if_addr = raddr(); bus.if_two = 1'($urandom_range(0, 1)); end
      else if (bus.if_req && $urandom_range(0, 7) == 0) bus.if_req = 0;
      if (!bus.mem_req && $urandom_range(0, 1) == 0) begin
        bus.mem_req = 1; bus.mem_we = 1'($urandom_range(0, 1)); bus.mem_addr = raddr(); bus.mem_wdata = 16'($urandom);
      end
      #1;
      eif = sp ? bus.if_req : bus.if_req && (!bus.mem_req || denied >= MAXS);
      emem = bus.mem_req && !eif;
      eaddr = eif ? (sp ? (base + 1) % 1024 : int'(bus.if_addr)) : emem ? int'(bus.mem_addr) : 0;
      ewr = emem && bus.mem_we;
      edin = ewr ? bus.mem_wdata : 16'h0;
      checks++; if ({bus.if_ack, bus.mem_ack} !== {eif, emem}) begin errors++; $display("FAIL rnd_grant n=%0d got=%b%b want=%b%b", n, bus.if_ack, bus.mem_ack, eif, emem); end
      checks++; if ({bus.ram_wr, bus.ram_addr, bus.ram_din} !== {ewr, 10'(eaddr), edin})
        begin errors++; $display("FAIL rnd_ram n=%0d got=%b/%h/%h want=%b/%h/%h", n, bus.ram_wr, bus.ram_addr, bus.ram_din, ewr, 10'(eaddr), edin); end
      checks++; if ({bus.if_valid, bus.if_word, bus.if_data} !== {rown == 1, rown == 1 && rword, (rown == 1) ? rdat : 16'h0})
        begin errors++; $display("FAIL rnd_ifrsp n=%0d got=%b%b/%h want=%b%b/%h", n, bus.if_valid, bus.if_word, bus.if_data, rown == 1, rown == 1 && rword, (rown == 1) ? rdat : 16'h0); end
      checks++; if ({bus.mem_valid, bus.mem_rdata} !== {rown == 2, (rown == 2) ? rdat : 16'h0})
        begin errors++; $display("FAIL rnd_memrsp n=%0d got=%b/%h want=%b/%h", n, bus.mem_valid, bus.mem_rdata, rown == 2, (rown == 2) ? rdat : 16'h0); end
      rown = eif ? 1 : (emem && !bus.mem_we) ? 2 : 0;
      rdat = shadow[eaddr];
      rword = eif && sp;
      if (ewr) shadow[eaddr] = edin;
      denied = (bus.if_req && !eif) ? ((denied < MAXS) ? denied + 1 : MAXS) : 0;
      if (eif && !sp) base = int'(bus.if_addr);
      sp = eif && !sp && bus.if_two;
      drop_if = eif && !sp;
      drop_mem = emem;
    end
    @(negedge clk); idle_inputs();
  endtask
  initial begin
    idle_inputs();
    bus.ram_dout = '0;
    preload();
    test_reset();
    test_contention();
    test_burst_wrap();
    test_flush();
    test_write_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
